data_memory_ctrl: RTL and testbench

//  Word-organised, byte-lane data memory with a valid/ready request port and a registered response.

---
 rtl/mem_pkg.sv | 25 ++
 rtl/mem_lane_align.sv | 49 ++++
 rtl/data_memory_ctrl.sv | 151 +++++++++++++++
 tb/tb_data_memory_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the data memory controller: access sizes,
// FSM state type and the byte-lane mask helper.
package mem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef logic [0:0] state_t;
    localparam state_t IDLE  = 1'b0;
    localparam state_t SPLIT = 1'b1;

    function automatic logic [7:0] lane_mask(input logic [1:0] size);
        logic [7:0] m;
        case (size)
            SZ_B:    m = 8'h01;
            SZ_H:    m = 8'h03;
            SZ_W:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane alignment over a two-word window: store mask/shift and
// load shift with sign/zero extension.
module mem_lane_align
    import mem_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    localparam int BYTES = WORD_SIZE / 8,
    localparam int OFF_W = $clog2(BYTES)
) (
    input  logic [OFF_W-1:0]       i_off,
    input  logic [1:0]             i_size,
    input  logic                   i_unsigned,
    input  logic [WORD_SIZE-1:0]   i_wdata,
    input  logic [2*WORD_SIZE-1:0] i_win,
    output logic [2*BYTES-1:0]     o_mask,
    output logic [2*WORD_SIZE-1:0] o_wwin,
    output logic [WORD_SIZE-1:0]   o_rdata
);

    logic [7:0]           w_lm;
    logic [WORD_SIZE-1:0] w_wd;
    logic [WORD_SIZE-1:0] w_raw;
    logic                 w_msb;
    logic                 w_sign;

    assign w_lm   = lane_mask(i_size);
    assign o_mask = (2*BYTES)'(w_lm) << i_off;
    assign o_wwin = {{WORD_SIZE{1'b0}}, w_wd} << {i_off, 3'b000};
    assign w_raw  = WORD_SIZE'(i_win >> {i_off, 3'b000});

    always_comb begin
        w_msb = w_raw[WORD_SIZE-1];
        case (i_size)
            SZ_B:    w_msb = w_raw[7];
            SZ_H:    w_msb = w_raw[15];
            SZ_W:    w_msb = w_raw[31];
            default: w_msb = w_raw[WORD_SIZE-1];
        endcase
    end

    assign w_sign = ~i_unsigned & w_msb;

    // Lanes outside the access are masked on store and extended on load.
    for (genvar b = 0; b < BYTES; b++) begin : g_lane
        assign w_wd[8*b +: 8]    = i_wdata[8*b +: 8] & {8{w_lm[b]}};
        assign o_rdata[8*b +: 8] = w_lm[b] ? w_raw[8*b +: 8] : {8{w_sign}};
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// Byte-lane data memory with valid/ready requests and registered responses.
// Define DMEM_MISALIGN_SPLIT_EN to allow misaligned and word-crossing access.
module data_memory_ctrl
    import mem_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int RAM_SIZE  = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [WORD_SIZE-1:0] req_addr,
    input  logic [WORD_SIZE-1:0] req_wdata,
    output logic                 rsp_valid,
    output logic [WORD_SIZE-1:0] rsp_rdata,
    output logic                 rsp_fault
);

    localparam int BYTES  = WORD_SIZE / 8;
    localparam int OFF_W  = $clog2(BYTES);
    localparam int AW     = $clog2(RAM_SIZE);
    localparam int IDX_W  = AW - OFF_W;
    localparam int NWORDS = RAM_SIZE / BYTES;

    logic [WORD_SIZE-1:0] r_mem [NWORDS];
    state_t               r_state;
    logic [IDX_W-1:0]     r_idx;
    logic [OFF_W-1:0]     r_off;
    logic [1:0]           r_size;
    logic                 r_uns;
    logic                 r_we;
    logic [WORD_SIZE-1:0] r_wdata;

    logic                   w_idle;
    logic                   w_acc;
    logic [IDX_W-1:0]       w_idx;
    logic [OFF_W-1:0]       w_off;
    logic [3:0]             w_nbytes;
    logic [AW:0]            w_end;
    logic                   w_range;
    logic                   w_badsz;
    logic                   w_fault;
    logic                   w_cross;
    logic [IDX_W-1:0]       w_a_idx;
    logic [IDX_W-1:0]       w_a_idx1;
    logic [2*WORD_SIZE-1:0] w_win;
    logic [2*BYTES-1:0]     w_mask;
    logic [2*WORD_SIZE-1:0] w_wwin;
    logic [WORD_SIZE-1:0]   w_rdata;
    logic                   w_wr_en;
    logic [IDX_W-1:0]       w_wr_idx;
    logic [BYTES-1:0]       w_wr_mask;
    logic [WORD_SIZE-1:0]   w_wr_data;

    assign w_idle    = (r_state == IDLE);
    assign req_ready = w_idle;
    assign w_acc     = req_valid & w_idle;
    assign w_idx     = req_addr[AW-1:OFF_W];
    assign w_off     = req_addr[OFF_W-1:0];
    assign w_nbytes  = 4'd1 << req_size;
    assign w_end     = {1'b0, req_addr[AW-1:0]} + (AW+1)'(w_nbytes) - (AW+1)'(1);
    assign w_range   = (|req_addr[WORD_SIZE-1:AW]) | w_end[AW];
    assign w_badsz   = (req_size == SZ_D) && (WORD_SIZE == 32);

`ifdef DMEM_MISALIGN_SPLIT_EN
    assign w_fault = w_badsz | w_range;
    assign w_cross = (5'(w_off) + 5'(w_nbytes)) > 5'(BYTES);
`else
    logic [2:0] w_amask;
    assign w_amask = w_nbytes[2:0] - 3'd1;
    assign w_fault = w_badsz | w_range | (|(req_addr[2:0] & w_amask));
    assign w_cross = 1'b0;
`endif

    // In SPLIT the aligner is re-driven from the held request for beat 2.
    assign w_a_idx  = w_idle ? w_idx : r_idx;
    assign w_a_idx1 = w_a_idx + IDX_W'(1);
    assign w_win    = {r_mem[w_a_idx1], r_mem[w_a_idx]};

    mem_lane_align #(.WORD_SIZE(WORD_SIZE)) u_align (
        .i_off      (w_idle ? w_off : r_off),
        .i_size     (w_idle ? req_size : r_size),
        .i_unsigned (w_idle ? req_unsigned : r_uns),
        .i_wdata    (w_idle ? req_wdata : r_wdata),
        .i_win      (w_win),
        .o_mask     (w_mask),
        .o_wwin     (w_wwin),
        .o_rdata    (w_rdata)
    );

    assign w_wr_en   = w_idle ? (w_acc & req_we & ~w_fault) : r_we;
    assign w_wr_idx  = w_idle ? w_a_idx : w_a_idx1;
    assign w_wr_mask = w_idle ? w_mask[BYTES-1:0] : w_mask[2*BYTES-1:BYTES];
    assign w_wr_data = w_idle ? w_wwin[WORD_SIZE-1:0]
                              : w_wwin[2*WORD_SIZE-1:WORD_SIZE];

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (w_wr_mask[b])
                    r_mem[w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_off     <= '0;
            r_size    <= '0;
            r_uns     <= 1'b0;
            r_we      <= 1'b0;
            r_wdata   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_fault <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (!w_idle) begin
                r_state   <= IDLE;
                rsp_valid <= 1'b1;
                rsp_fault <= 1'b0;
                rsp_rdata <= r_we ? '0 : w_rdata;
            end else if (w_acc) begin
                if (w_fault) begin
                    rsp_valid <= 1'b1;
                    rsp_fault <= 1'b1;
                    rsp_rdata <= '0;
                end else if (w_cross) begin
                    r_state <= SPLIT;
                    r_idx   <= w_idx;
                    r_off   <= w_off;
                    r_size  <= req_size;
                    r_uns   <= req_unsigned;
                    r_we    <= req_we;
                    r_wdata <= req_wdata;
                end else begin
                    rsp_valid <= 1'b1;
                    rsp_fault <= 1'b0;
                    rsp_rdata <= req_we ? '0 : w_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed-vector bench for data_memory_ctrl (32-bit word, 1 KiB).
// Split-path expectations follow DMEM_MISALIGN_SPLIT_EN when defined.
module tb_data_memory_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    data_memory_ctrl #(.WORD_SIZE(32), .RAM_SIZE(1024)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_fault    (rsp_fault)
    );

    // Issue one request; lat = cycles from accept to rsp_valid, 0 if none.
    task automatic do_req(input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr,
                          input logic [31:0] wdata,
                          output logic [31:0] rd, output logic flt,
                          output int lat, output logic rdy1);
        int n;
        req_valid = 1'b1;
        req_we = we;
        req_size = size;
        req_unsigned = uns;
        req_addr = addr;
        req_wdata = wdata;
        n = 0;
        while (!req_ready && n < 8) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        rdy1 = req_ready;
        lat = 1;
        while (!rsp_valid && lat < 4) begin
            @(posedge clk); #1; lat++;
        end
        if (!rsp_valid) lat = 0;
        rd = rsp_rdata;
        flt = rsp_fault;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_size = 2'd0;
        req_unsigned = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b want 1", req_ready); end
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", rsp_valid); end
        n_vec++; if (rsp_rdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata got %h want 0", rsp_rdata); end
        n_vec++; if (rsp_fault !== 1'b0) begin n_err++; $display("FAIL rst_fault got %b want 0", rsp_fault); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        req_valid = 1'b1;
        req_we = 1'b1;
        req_size = 2'd2;
        req_unsigned = 1'b0;
        req_addr = 32'h10;
        req_wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL sw_valid got %b want 1", rsp_valid); end
        n_vec++; if (rsp_fault !== 1'b0) begin n_err++; $display("FAIL sw_fault got %b want 0", rsp_fault); end
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready got %b want 1", req_ready); end
        req_we = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL lw_valid got %b want 1", rsp_valid); end
        n_vec++; if (rsp_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL lw_data got %h want deadbeef", rsp_rdata); end
        n_vec++; if (rsp_fault !== 1'b0) begin n_err++; $display("FAIL lw_fault got %b want 0", rsp_fault); end
        @(posedge clk); #1;
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rsp_pulse got %b want 0", rsp_valid); end
    endtask

    task automatic test_load_ext;
        logic [31:0] rd;
        logic f, r1;
        int lat;
        do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, rd, f, lat, r1);
        n_vec++; if (rd !== 32'hFFFFFFDE) begin n_err++; $display("FAIL lb got %h want ffffffde", rd); end
        n_vec++; if (lat !== 1) begin n_err++; $display("FAIL lb_lat got %0d want 1", lat); end
        do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, rd, f, lat, r1);
        n_vec++; if (rd !== 32'h000000DE) begin n_err++; $display("FAIL lbu got %h want 000000de", rd); end
        do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, rd, f, lat, r1);
        n_vec++; if (rd !== 32'hFFFFDEAD) begin n_err++; $display("FAIL lh got %h want ffffdead", rd); end
        do_req(1'b0, 2'd1, 1'b1, 32'h10, 32'h0, rd, f, lat, r1);
        n_vec++; if (rd !== 32'h0000BEEF) begin n_err++; $display("FAIL lhu got %h want 0000beef", rd); end
        do_req(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, rd, f, lat, r1);
        n_vec++; if (rd !== 32'hFFFFFFEF) begin n_err++; $display("FAIL lb0 got %h want ffffffef", rd); end
    endtask

    task automatic test_byte_store;
        logic [31:0] rd;
        logic f, r1;
        int lat;
        do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'hFFFFFF55, rd, f, lat, r1);
        n_vec++; if (f !== 1'b0) begin n_err++; $display("FAIL sb_fault got %b want 0", f); end
        n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL sb_rdata got %h want 0", rd); end
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, f, lat, r1);
        n_vec++; if (rd !== 32'hDEAD55EF) begin n_err++; $display("FAIL sb_word got %h want dead55ef", rd); end
    endtask

    task automatic test_fault;
        logic [31:0] rd;
        logic f, r1;
        int lat;
        do_req(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, rd, f, lat, r1);
        n_vec++; if (f !== 1'b1) begin n_err++; $display("FAIL oor_fault got %b want 1", f); end
        n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL oor_rdata got %h want 0", rd); end
        n_vec++; if (lat !== 1) begin n_err++; $display("FAIL oor_lat got %0d want 1", lat); end
        do_req(1'b0, 2'd2, 1'b0, 32'h80000010, 32'h0, rd, f, lat, r1);
        n_vec++; if (f !== 1'b1) begin n_err++; $display("FAIL upper_fault got %b want 1", f); end
        do_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, rd, f, lat, r1);
        n_vec++; if (f !== 1'b1) begin n_err++; $display("FAIL dsize_fault got %b want 1", f); end
        do_req(1'b1, 2'd2, 1'b0, 32'h3FC, 32'hCAFEF00D, rd, f, lat, r1);
        n_vec++; if (f !== 1'b0) begin n_err++; $display("FAIL top_sw_fault got %b want 0", f); end
        do_req(1'b1, 2'd2, 1'b0, 32'h3FE, 32'h12345678, rd, f, lat, r1);
        n_vec++; if (f !== 1'b1) begin n_err++; $display("FAIL cross_top_fault got %b want 1", f); end
        do_req(1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0, rd, f, lat, r1);
        n_vec++; if (rd !== 32'hCAFEF00D) begin n_err++; $display("FAIL top_keep got %h want cafef00d", rd); end
    endtask

    task automatic test_misalign;
        logic [31:0] rd;
        logic f, r1;
        int lat;
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h0, rd, f, lat, r1);
        do_req(1'b1, 2'd2, 1'b0, 32'h14, 32'h0, rd, f, lat, r1);
        do_req(1'b1, 2'd2, 1'b0, 32'h12, 32'h11223344, rd, f, lat, r1);
`ifdef DMEM_MISALIGN_SPLIT_EN
        n_vec++; if (f !== 1'b0) begin n_err++; $display("FAIL split_fault got %b want 0", f); end
        n_vec++; if (lat !== 2) begin n_err++; $display("FAIL split_lat got %0d want 2", lat); end
        n_vec++; if (r1 !== 1'b0) begin n_err++; $display("FAIL split_ready got %b want 0", r1); end
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, f, lat, r1);
        n_vec++; if (rd !== 32'h33440000) begin n_err++; $display("FAIL split_lo got %h want 33440000", rd); end
        do_req(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, rd, f, lat, r1);
        n_vec++; if (rd !== 32'h00001122) begin n_err++; $display("FAIL split_hi got %h want 00001122", rd); end
        do_req(1'b0, 2'd2, 1'b0, 32'h12, 32'h0, rd, f, lat, r1);
        n_vec++; if (rd !== 32'h11223344) begin n_err++; $display("FAIL split_ld got %h want 11223344", rd); end
        n_vec++; if (lat !== 2) begin n_err++; $display("FAIL split_ld_lat got %0d want 2", lat); end
        do_req(1'b0, 2'd1, 1'b0, 32'h11, 32'h0, rd, f, lat, r1);
        n_vec++; if (rd !== 32'h00004400) begin n_err++; $display("FAIL inword_lh got %h want 00004400", rd); end
        n_vec++; if (lat !== 1) begin n_err++; $display("FAIL inword_lat got %0d want 1", lat); end
`else
        n_vec++; if (f !== 1'b1) begin n_err++; $display("FAIL mis_fault got %b want 1", f); end
        n_vec++; if (lat !== 1) begin n_err++; $display("FAIL mis_lat got %0d want 1", lat); end
        n_vec++; if (r1 !== 1'b1) begin n_err++; $display("FAIL mis_ready got %b want 1", r1); end
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, f, lat, r1);
        n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL mis_nowr_lo got %h want 0", rd); end
        do_req(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, rd, f, lat, r1);
        n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL mis_nowr_hi got %h want 0", rd); end
        do_req(1'b0, 2'd1, 1'b0, 32'h11, 32'h0, rd, f, lat, r1);
        n_vec++; if (f !== 1'b1) begin n_err++; $display("FAIL mis_lh_fault got %b want 1", f); end
`endif
    endtask

    task automatic test_reset_split;
        logic [31:0] rd;
        logic f, r1;
        int lat;
`ifdef DMEM_MISALIGN_SPLIT_EN
        do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h0, rd, f, lat, r1);
        do_req(1'b1, 2'd2, 1'b0, 32'h24, 32'h0, rd, f, lat, r1);
        req_valid = 1'b1;
        req_we = 1'b1;
        req_size = 2'd2;
        req_addr = 32'h22;
        req_wdata = 32'hAABBCCDD;
`else
        req_valid = 1'b1;
        req_we = 1'b0;
        req_size = 2'd2;
        req_addr = 32'h10;
        req_wdata = 32'h0;
`endif
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid got %b want 0", rsp_valid); end
        @(posedge clk); #1;
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid2 got %b want 0", rsp_valid); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ready got %b want 1", req_ready); end
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid3 got %b want 0", rsp_valid); end
`ifdef DMEM_MISALIGN_SPLIT_EN
        do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, f, lat, r1);
        n_vec++; if (rd !== 32'hCCDD0000) begin n_err++; $display("FAIL beat1_kept got %h want ccdd0000", rd); end
        do_req(1'b0, 2'd2, 1'b0, 32'h24, 32'h0, rd, f, lat, r1);
        n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL beat2_skip got %h want 0", rd); end
`else
        do_req(1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0, rd, f, lat, r1);
        n_vec++; if (rd !== 32'hCAFEF00D) begin n_err++; $display("FAIL post_rst got %h want cafef00d", rd); end
`endif
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load_ext();
        test_byte_store();
        test_fault();
        test_misalign();
        test_reset_split();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
